// File: rtl/fnd_scan_decoder_if.sv
// rtl/fnd_scan_decoder_if.sv - display value in, digit enables/segments/busy out
interface fnd_scan_decoder_if;
    logic [13:0] fndData;
    logic [3:0]  fndCom;
    logic [7:0]  fndFont;
    logic        conv_busy;

    modport master (output fndData, input fndCom, input fndFont, input conv_busy);
    modport slave  (input fndData, output fndCom, output fndFont, output conv_busy);
endinterface

// File: rtl/fnd_scan_decoder.sv
// rtl/fnd_scan_decoder.sv - binary-to-BCD double-dabble plus 4-digit 7-seg scanner
// Optional leading-zero blanking: define FND_LEAD_ZERO_BLANK_EN.
module fnd_scan_decoder #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic                clk,
    input  logic                reset,
    fnd_scan_decoder_if.slave   bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t        r_state;
    logic [13:0]   r_bin;
    logic [15:0]   r_scratch;
    logic [15:0]   r_bcd;
    logic [3:0]    r_bit_cnt;
    logic          r_busy;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [3:0]    r_com;
    logic [7:0]    r_font;

    logic [13:0]   w_sample;
    logic [15:0]   w_adj;
    logic          w_tick;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic [3:0]    w_com;

    assign w_sample = (bus.fndData > 14'd9999) ? 14'd9999 : bus.fndData;

    always_comb begin
        w_adj = r_scratch;
        for (int k = 0; k < 4; k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5)
                w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
        end
    end

    // Conversion FSM: one sample cycle, 14 shift cycles, one load cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_bin     <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_bin     <= w_sample;
                    r_scratch <= '0;
                    r_bit_cnt <= '0;
                    r_busy    <= 1'b1;
                    r_state   <= SHIFT;
                end
                SHIFT: begin
                    {r_scratch, r_bin} <= {w_adj, r_bin} << 1;
                    r_bit_cnt          <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd13)
                        r_state <= LOAD;
                end
                LOAD: begin
                    r_bcd   <= r_scratch;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick)
                r_idx <= r_idx + 2'd1;
        end
    end

    always_comb begin
        w_nib = r_bcd[3:0];
        w_com = 4'b1110;
        case (r_idx)
            2'd0: begin w_nib = r_bcd[3:0];   w_com = 4'b1110; end
            2'd1: begin w_nib = r_bcd[7:4];   w_com = 4'b1101; end
            2'd2: begin w_nib = r_bcd[11:8];  w_com = 4'b1011; end
            2'd3: begin w_nib = r_bcd[15:12]; w_com = 4'b0111; end
            default: begin w_nib = r_bcd[3:0]; w_com = 4'b1110; end
        endcase
    end

`ifdef FND_LEAD_ZERO_BLANK_EN
    // A digit blanks only when it and every higher digit are zero; ones never blanks
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd3: w_blank = (r_bcd[15:12] == 4'd0);
            2'd2: w_blank = (r_bcd[15:8] == 8'd0);
            2'd1: w_blank = (r_bcd[15:4] == 12'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_com  <= 4'b1110;
            r_font <= 8'hC0;
        end else begin
            r_com  <= w_com;
            r_font <= w_blank ? 8'hFF : seg7(w_nib);
        end
    end

    assign bus.fndCom    = r_com;
    assign bus.fndFont   = r_font;
    assign bus.conv_busy = r_busy;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// tb/tb_fnd_scan_decoder.sv - directed checks of conversion, scanning and reset
module tb_fnd_scan_decoder;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    fnd_scan_decoder_if bus ();

    fnd_scan_decoder #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.conv_busy === lvl) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic busy_run(input string tag);
        logic ok;
        int   n;
        wait_busy(1'b1, ok);
        check({tag, "_rise"}, {15'd0, ok}, 16'd1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.conv_busy !== 1'b1) break;
            n++;
            step();
        end
        check({tag, "_len"}, 16'(n), 16'd15);
    endtask

    // Align on the start of the ones slot, then walk the four slots in order
    task automatic show_digits(input string tag, input logic [7:0] f3, input logic [7:0] f2,
                               input logic [7:0] f1, input logic [7:0] f0);
        logic       found;
        logic [3:0] prev;
        logic [7:0] fexp [4];
        logic [3:0] cexp [4];
        fexp[0] = f0; fexp[1] = f1; fexp[2] = f2; fexp[3] = f3;
        cexp[0] = 4'b1110; cexp[1] = 4'b1101; cexp[2] = 4'b1011; cexp[3] = 4'b0111;
        found = 1'b0;
        prev  = bus.fndCom;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.fndCom === 4'b1110 && prev !== 4'b1110) begin
                found = 1'b1;
                break;
            end
            prev = bus.fndCom;
        end
        check({tag, "_align"}, {15'd0, found}, 16'd1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (4) step();
            check($sformatf("%s_com%0d", tag, k), {12'd0, bus.fndCom}, {12'd0, cexp[k]});
            check($sformatf("%s_font%0d", tag, k), {8'd0, bus.fndFont}, {8'd0, fexp[k]});
        end
    endtask

    task automatic ones_in_window(input string tag, input logic [7:0] fexp);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.fndCom === 4'b1110) begin
                found = 1'b1;
                check({tag, "_font"}, {8'd0, bus.fndFont}, {8'd0, fexp});
                break;
            end
        end
        check({tag, "_found"}, {15'd0, found}, 16'd1);
    endtask

    initial begin
        logic ok;
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        bus.fndData = 14'd1234;
        repeat (3) step();
        check("rst_com", {12'd0, bus.fndCom}, 16'h000E);
        check("rst_font", {8'd0, bus.fndFont}, 16'h00C0);
        check("rst_busy", {15'd0, bus.conv_busy}, 16'd0);

        @(negedge clk);
        reset = 1'b1;
        busy_run("busy1234");
        show_digits("d1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);

        bus.fndData = 14'd9999;
        repeat (40) step();
        show_digits("d9999", 8'h90, 8'h90, 8'h90, 8'h90);
        bus.fndData = 14'd0;
        repeat (40) step();
`ifdef FND_LEAD_ZERO_BLANK_EN
        show_digits("d0", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
`else
        show_digits("d0", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif

        bus.fndData = 14'd16383;
        repeat (40) step();
        show_digits("dclamp", 8'h90, 8'h90, 8'h90, 8'h90);

        bus.fndData = 14'd7;
        repeat (40) step();
`ifdef FND_LEAD_ZERO_BLANK_EN
        show_digits("d7", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
`else
        show_digits("d7", 8'hC0, 8'hC0, 8'hC0, 8'hF8);
`endif

        // Reset in the middle of SHIFT
        bus.fndData = 14'd1234;
        wait_busy(1'b0, ok);
        check("mid_wait0", {15'd0, ok}, 16'd1);
        wait_busy(1'b1, ok);
        check("mid_wait1", {15'd0, ok}, 16'd1);
        repeat (8) step();
        reset = 1'b0;
        #1;
        check("mid_rst_com", {12'd0, bus.fndCom}, 16'h000E);
        check("mid_rst_font", {8'd0, bus.fndFont}, 16'h00C0);
        check("mid_rst_busy", {15'd0, bus.conv_busy}, 16'd0);
        repeat (2) step();
        reset = 1'b1;
        step();
        check("post_rst_com", {12'd0, bus.fndCom}, 16'h000E);
        check("post_rst_font", {8'd0, bus.fndFont}, 16'h00C0);
        busy_run("busy_rerun");
        show_digits("d1234b", 8'hF9, 8'hA4, 8'hB0, 8'h99);

        // Input change during SHIFT is held off until the next sample
        bus.fndData = 14'd5;
        repeat (40) step();
        wait_busy(1'b0, ok);
        check("tog_wait0", {15'd0, ok}, 16'd1);
        wait_busy(1'b1, ok);
        check("tog_wait1", {15'd0, ok}, 16'd1);
        repeat (3) step();
        bus.fndData = 14'd6;
        wait_busy(1'b0, ok);
        check("tog_load5", {15'd0, ok}, 16'd1);
        ones_in_window("tog5", 8'h92);
        wait_busy(1'b1, ok);
        wait_busy(1'b0, ok);
        check("tog_load6", {15'd0, ok}, 16'd1);
        ones_in_window("tog6", 8'h82);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
